// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipe_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] MDU    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] VECTOR = 2'd3;

  typedef enum logic [1:0] {
    StRun    = RUN,
    StMdu    = MDU,
    StDrain  = DRAIN,
    StVector = VECTOR
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and per-stage control outputs between the sequencer and the pipeline.
interface pipe_ctrl_if;
  logic ld_use_stall;
  logic br_taken;
  logic imem_ready;
  logic dmem_ready;
  logic mdu_start;
  logic irq_req;
  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic idex_en;
  logic idex_flush;
  logic exmem_en;
  logic exmem_flush;
  logic memwb_en;
  logic mdu_busy;
  logic mdu_done;
  logic irq_ack;

  modport master (
    input  ld_use_stall, br_taken, imem_ready, dmem_ready, mdu_start, irq_req,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, mdu_busy, mdu_done, irq_ack
  );

  modport slave (
    output ld_use_stall, br_taken, imem_ready, dmem_ready, mdu_start, irq_req,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, mdu_busy, mdu_done, irq_ack
  );
endinterface

// File: rtl/pipe_ctrl_cnt.sv
// Loadable down-counter for MDU occupancy and interrupt drain; saturates at zero.
module pipe_ctrl_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && !zero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: merges load-use, branch, memory waits, MUL/DIV occupancy
// and interrupt entry into per-stage enables/flushes and the PC enable.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT   = 8,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  state_e           state_q;
  logic             run_ok, mdu_go, irq_go;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  // A RUN cycle may start a new sequence only when nothing of higher priority claims it.
  assign run_ok    = (state_q == StRun) && bus.dmem_ready && !bus.br_taken && !bus.ld_use_stall;
  assign mdu_go    = run_ok && bus.mdu_start;
  assign irq_go    = run_ok && bus.imem_ready && !bus.mdu_start && bus.irq_req;
  assign cnt_load  = mdu_go || irq_go;
  assign cnt_value = mdu_go ? CNT_W'(MDU_LAT - 2) : CNT_W'(DRAIN_CYC - 1);
  assign cnt_en    = bus.dmem_ready && ((state_q == StMdu) || (state_q == StDrain));

  pipe_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .en    (cnt_en),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mdu_go) begin
            state_q <= StMdu;
          end else if (irq_go) begin
            state_q <= StDrain;
          end
        end
        StMdu: begin
          if (bus.dmem_ready && cnt_zero) state_q <= StRun;
        end
        StDrain: begin
          if (bus.dmem_ready && cnt_zero) state_q <= bus.irq_req ? StVector : StRun;
        end
        StVector: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_en     = 1'b1;
    bus.idex_flush  = 1'b0;
    bus.exmem_en    = 1'b1;
    bus.exmem_flush = 1'b0;
    bus.memwb_en    = 1'b1;
    bus.mdu_busy    = 1'b0;
    bus.mdu_done    = 1'b0;
    bus.irq_ack     = 1'b0;
    if (rst) begin
      bus.pc_en       = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!bus.dmem_ready) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
          end else if (bus.br_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
          end else if (bus.ld_use_stall) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
          end else if (bus.mdu_start) begin
            // First MDU cycle already holds EX, so it counts towards MDU_LAT.
            bus.mdu_busy    = 1'b1;
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_flush = 1'b1;
          end else if (!bus.imem_ready) begin
            bus.pc_en      = 1'b0;
            bus.ifid_flush = 1'b1;
          end
        end
        StMdu: begin
          bus.mdu_busy = 1'b1;
          bus.pc_en    = 1'b0;
          bus.ifid_en  = 1'b0;
          bus.idex_en  = 1'b0;
          if (!bus.dmem_ready) begin
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
          end else if (cnt_zero) begin
            bus.mdu_done = 1'b1;
          end else begin
            bus.exmem_flush = 1'b1;
          end
        end
        StDrain: begin
          bus.pc_en = 1'b0;
          if (!bus.dmem_ready) begin
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
          end else begin
            bus.ifid_flush = 1'b1;
          end
        end
        StVector: begin
          bus.irq_ack    = 1'b1;
          bus.ifid_flush = 1'b1;
          bus.idex_en    = bus.dmem_ready;
          bus.exmem_en   = bus.dmem_ready;
          bus.memwb_en   = bus.dmem_ready;
        end
      endcase
    end
  end

endmodule
